// File: rtl/audio_arbiter_pkg.sv
// Shared definitions for the audio arbiter: note codes, SFX ids, step ROM and FSM states.
package audio_arbiter_pkg;

    typedef logic [11:0] note_t;
    typedef logic [1:0]  sfx_t;
    typedef logic [1:0]  step_t;

    localparam note_t NOTE_REST = 12'h000;

    localparam sfx_t SFX_NONE  = 2'd0;
    localparam sfx_t SFX_FLAP  = 2'd1;
    localparam sfx_t SFX_SCORE = 2'd2;
    localparam sfx_t SFX_HIT   = 2'd3;

    // Row index is the SFX id; unused slots hold rests.
    localparam note_t SFX_ROM [4][4] = '{
        '{NOTE_REST, NOTE_REST, NOTE_REST, NOTE_REST},
        '{12'h050,   12'h100,   NOTE_REST, NOTE_REST},
        '{12'h100,   12'h300,   12'h500,   NOTE_REST},
        '{12'h030,   12'h020,   12'h010,   12'h001}
    };

    // Index of the final step of each sequence (length - 1).
    localparam step_t SFX_LAST [4] = '{2'd0, 2'd1, 2'd2, 2'd3};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_GAP
    } state_t;

    function automatic sfx_t prio_id(input logic [2:0] req);
        if (req[2])      return SFX_HIT;
        else if (req[1]) return SFX_SCORE;
        else if (req[0]) return SFX_FLAP;
        else             return SFX_NONE;
    endfunction

endpackage

// File: rtl/audio_arbiter_if.sv
// Beat-rate control and note bus between the game logic and the audio arbiter.
interface audio_arbiter_if;
    logic        tick;
    logic [11:0] bgm_note;
    logic        bgm_en;
    logic        mute;
    logic [2:0]  sfx_req;
    logic [11:0] note;
    logic        sfx_busy;
    logic [1:0]  sfx_id;

    modport master (
        output tick, bgm_note, bgm_en, mute, sfx_req,
        input  note, sfx_busy, sfx_id
    );

    modport slave (
        input  tick, bgm_note, bgm_en, mute, sfx_req,
        output note, sfx_busy, sfx_id
    );
endinterface

// File: rtl/audio_arbiter_sfx_rom.sv
// Combinational SFX step ROM: (id, step) -> note code plus a last-step flag.
module audio_arbiter_sfx_rom
    import audio_arbiter_pkg::*;
(
    input  sfx_t  id,
    input  step_t step,
    output note_t note,
    output logic  last
);

    always_comb begin
        note = SFX_ROM[id][step];
        last = (step >= SFX_LAST[id]);
    end

endmodule

// File: rtl/audio_arbiter.sv
// Tone-generator arbiter: BGM by default, prioritised preemptive SFX sequences,
// then a rest gap before BGM resumes. All outputs update only on beat ticks.
module audio_arbiter
    import audio_arbiter_pkg::*;
#(
    parameter int unsigned GAP_TICKS = 1
) (
    input  logic           clk,
    input  logic           rst,
    audio_arbiter_if.slave bus
);

    localparam logic [2:0] GAP_LIM = GAP_TICKS[2:0];

    state_t     state, state_nx;
    sfx_t       pend, pend_nx;
    sfx_t       sfx_id, sfx_id_nx;
    step_t      step, step_nx;
    logic [2:0] gap_cnt, gap_cnt_nx;
    note_t      note, note_nx;
    logic       last_q, last_nx;

    sfx_t       req_id, req_acc, eff;
    logic       start;
    sfx_t       play_id;
    step_t      play_step;
    note_t      rom_note;
    logic       rom_last;
    note_t      bgm_out, out;

    // Single ROM lookup: the note about to be emitted; its last flag is kept
    // in last_q so the following tick knows the sequence has finished.
    audio_arbiter_sfx_rom u_rom (
        .id   (play_id),
        .step (play_step),
        .note (rom_note),
        .last (rom_last)
    );

    always_comb begin
        req_id  = prio_id(bus.sfx_req);
        req_acc = (state != ST_PLAY || req_id > sfx_id) ? req_id : SFX_NONE;
        eff     = (req_acc > pend) ? req_acc : pend;
        // sfx_id is zero outside PLAY, so this covers both start and preemption.
        start     = (eff > sfx_id);
        play_id   = start ? eff : sfx_id;
        play_step = start ? 2'd0 : step + 2'd1;
        bgm_out   = bus.bgm_en ? bus.bgm_note : NOTE_REST;
    end

    always_comb begin
        state_nx   = state;
        pend_nx    = eff;
        sfx_id_nx  = sfx_id;
        step_nx    = step;
        gap_cnt_nx = gap_cnt;
        last_nx    = last_q;
        note_nx    = note;
        out        = NOTE_REST;

        if (bus.tick) begin
            pend_nx = SFX_NONE;
            if (start) begin
                state_nx  = ST_PLAY;
                sfx_id_nx = eff;
                step_nx   = 2'd0;
                last_nx   = rom_last;
                out       = rom_note;
            end else begin
                case (state)
                    ST_PLAY: begin
                        if (last_q) begin
                            sfx_id_nx = SFX_NONE;
                            last_nx   = 1'b0;
                            step_nx   = 2'd0;
                            if (GAP_TICKS == 0) begin
                                state_nx = ST_IDLE;
                                out      = bgm_out;
                            end else begin
                                state_nx   = ST_GAP;
                                gap_cnt_nx = 3'd1;
                                out        = NOTE_REST;
                            end
                        end else begin
                            step_nx = play_step;
                            last_nx = rom_last;
                            out     = rom_note;
                        end
                    end
                    ST_GAP: begin
                        if (gap_cnt >= GAP_LIM) begin
                            state_nx   = ST_IDLE;
                            gap_cnt_nx = 3'd0;
                            out        = bgm_out;
                        end else begin
                            gap_cnt_nx = gap_cnt + 3'd1;
                            out        = NOTE_REST;
                        end
                    end
                    default: out = bgm_out;
                endcase
            end
            note_nx = bus.mute ? NOTE_REST : out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pend    <= SFX_NONE;
            sfx_id  <= SFX_NONE;
            step    <= 2'd0;
            gap_cnt <= 3'd0;
            last_q  <= 1'b0;
            note    <= NOTE_REST;
        end else begin
            state   <= state_nx;
            pend    <= pend_nx;
            sfx_id  <= sfx_id_nx;
            step    <= step_nx;
            gap_cnt <= gap_cnt_nx;
            last_q  <= last_nx;
            note    <= note_nx;
        end
    end

    assign bus.note     = note;
    assign bus.sfx_id   = sfx_id;
    assign bus.sfx_busy = (state == ST_PLAY);

endmodule

// File: tb/tb_audio_arbiter.sv
// Bench for audio_arbiter: directed vector table, reset corner case, and random
// stimulus against a queue-free behavioural model for GAP_TICKS = 1 and 0.
module tb_audio_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        tick;
    logic [2:0]  req;
    logic [11:0] bgm;
    logic        bgm_en;
    logic        mute;

    int vectors    = 0;
    int miscompares = 0;

    audio_arbiter_if bus0 ();
    audio_arbiter_if bus1 ();

    assign bus0.tick = tick;   assign bus1.tick = tick;
    assign bus0.sfx_req = req; assign bus1.sfx_req = req;
    assign bus0.bgm_note = bgm; assign bus1.bgm_note = bgm;
    assign bus0.bgm_en = bgm_en; assign bus1.bgm_en = bgm_en;
    assign bus0.mute = mute;   assign bus1.mute = mute;

    audio_arbiter #(.GAP_TICKS(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    audio_arbiter #(.GAP_TICKS(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    always #5 clk = ~clk;

    // Reference model: current effect, position in its note list, rests left.
    int          GAPS [2] = '{1, 0};
    int          SLEN [4] = '{0, 2, 3, 4};
    logic [11:0] SEQ  [4][4] = '{
        '{12'h000, 12'h000, 12'h000, 12'h000},
        '{12'h050, 12'h100, 12'h000, 12'h000},
        '{12'h100, 12'h300, 12'h500, 12'h000},
        '{12'h030, 12'h020, 12'h010, 12'h001}
    };
    int          m_cur [2];
    int          m_pos [2];
    int          m_rest[2];
    int          m_pend[2];
    logic [11:0] m_note[2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cur[k] = 0; m_pos[k] = 0; m_rest[k] = 0; m_pend[k] = 0;
            m_note[k] = 12'h000;
        end
    endtask

    task automatic model_clock(input int k);
        int rid;
        int eff;
        logic [11:0] o;
        rid = req[2] ? 3 : req[1] ? 2 : req[0] ? 1 : 0;
        if (m_cur[k] != 0 && rid <= m_cur[k]) rid = 0;
        eff = (rid > m_pend[k]) ? rid : m_pend[k];
        if (!tick) begin
            m_pend[k] = eff;
            return;
        end
        m_pend[k] = 0;
        if (eff > m_cur[k]) begin
            m_cur[k] = eff; m_rest[k] = 0;
            o = SEQ[eff][0]; m_pos[k] = 1;
        end else if (m_cur[k] != 0 && m_pos[k] < SLEN[m_cur[k]]) begin
            o = SEQ[m_cur[k]][m_pos[k]]; m_pos[k]++;
        end else if (m_cur[k] != 0) begin
            m_cur[k] = 0;
            if (GAPS[k] > 0) begin m_rest[k] = GAPS[k] - 1; o = 12'h000; end
            else o = bgm_en ? bgm : 12'h000;
        end else if (m_rest[k] > 0) begin
            m_rest[k]--; o = 12'h000;
        end else begin
            o = bgm_en ? bgm : 12'h000;
        end
        m_note[k] = mute ? 12'h000 : o;
    endtask

    task automatic check(input string name, input logic [11:0] an, input logic ab,
                         input logic [1:0] ai, input logic [11:0] en, input logic eb,
                         input logic [1:0] ei);
        vectors++;
        if (an !== en || ab !== eb || ai !== ei) begin
            miscompares++;
            $display("FAIL %s @%0t: got note=%h busy=%b id=%0d, want note=%h busy=%b id=%0d",
                     name, $time, an, ab, ai, en, eb, ei);
        end
    endtask

    task automatic check_models(input string name);
        check({name, "/gap1"}, bus0.note, bus0.sfx_busy, bus0.sfx_id,
              m_note[0], m_cur[0] != 0, 2'(m_cur[0]));
        check({name, "/gap0"}, bus1.note, bus1.sfx_busy, bus1.sfx_id,
              m_note[1], m_cur[1] != 0, 2'(m_cur[1]));
    endtask

    task automatic cycle(input logic tk, input logic [2:0] rq);
        tick = tk; req = rq;
        @(posedge clk);
        if (rst) model_reset();
        else begin model_clock(0); model_clock(1); end
        #1;
        tick = 1'b0; req = 3'b000;
    endtask

    typedef struct {
        logic        tk;
        logic [2:0]  rq;
        logic [11:0] bn;
        logic        be;
        logic        mu;
        logic [11:0] en;
        logic        eb;
        logic [1:0]  ei;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic tk, input logic [2:0] rq, input logic [11:0] bn,
                                input logic be, input logic mu, input logic [11:0] en,
                                input logic eb, input logic [1:0] ei);
        vec_t r;
        r.tk = tk; r.rq = rq; r.bn = bn; r.be = be; r.mu = mu;
        r.en = en; r.eb = eb; r.ei = ei;
        return r;
    endfunction

    initial begin
        // Expected outputs are for the GAP_TICKS = 1 instance after each clock.
        // idle BGM, then bgm_en low
        tbl.push_back(mk(1'b1, 3'b000, 12'h030, 1'b1, 1'b0, 12'h030, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 3'b000, 12'h030, 1'b1, 1'b0, 12'h030, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h030, 1'b0, 1'b0, 12'h000, 1'b0, 2'd0));
        // flap requested between ticks
        tbl.push_back(mk(1'b0, 3'b001, 12'h222, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h050, 1'b1, 2'd1));
        tbl.push_back(mk(1'b0, 3'b000, 12'h222, 1'b1, 1'b0, 12'h050, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h100, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h222, 1'b0, 2'd0));
        // hit preempts flap on its second tick
        tbl.push_back(mk(1'b1, 3'b001, 12'h222, 1'b1, 1'b0, 12'h050, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 3'b100, 12'h222, 1'b1, 1'b0, 12'h030, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h020, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h010, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h001, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h222, 1'b0, 2'd0));
        // flap during score is discarded, both between and on ticks
        tbl.push_back(mk(1'b1, 3'b010, 12'h222, 1'b1, 1'b0, 12'h100, 1'b1, 2'd2));
        tbl.push_back(mk(1'b0, 3'b001, 12'h222, 1'b1, 1'b0, 12'h100, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h300, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 3'b001, 12'h222, 1'b1, 1'b0, 12'h500, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h222, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h222, 1'b0, 2'd0));
        // simultaneous flap+score, mute mid-score
        tbl.push_back(mk(1'b1, 3'b011, 12'h222, 1'b1, 1'b0, 12'h100, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b1, 12'h000, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h500, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h222, 1'b0, 2'd0));
        // score requested during the rest gap starts at the next tick
        tbl.push_back(mk(1'b1, 3'b001, 12'h222, 1'b1, 1'b0, 12'h050, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h100, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 3'b010, 12'h222, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h100, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h300, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h500, 1'b1, 2'd2));
        tbl.push_back(mk(1'b1, 3'b000, 12'h222, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h777, 1'b0, 2'd0));
        // mute in idle, then same-priority retrigger is ignored
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b1, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h777, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b001, 12'h777, 1'b1, 1'b0, 12'h050, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 3'b001, 12'h777, 1'b1, 1'b0, 12'h100, 1'b1, 2'd1));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h777, 1'b0, 2'd0));
        // flap pending, upgraded to hit before the tick
        tbl.push_back(mk(1'b0, 3'b001, 12'h777, 1'b1, 1'b0, 12'h777, 1'b0, 2'd0));
        tbl.push_back(mk(1'b0, 3'b100, 12'h777, 1'b1, 1'b0, 12'h777, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h030, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h020, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h010, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h001, 1'b1, 2'd3));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h000, 1'b0, 2'd0));
        tbl.push_back(mk(1'b1, 3'b000, 12'h777, 1'b1, 1'b0, 12'h777, 1'b0, 2'd0));

        rst = 1'b1; tick = 1'b0; req = 3'b000; bgm = 12'h000; bgm_en = 1'b0; mute = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset/gap1", bus0.note, bus0.sfx_busy, bus0.sfx_id, 12'h000, 1'b0, 2'd0);
        check("reset/gap0", bus1.note, bus1.sfx_busy, bus1.sfx_id, 12'h000, 1'b0, 2'd0);

        foreach (tbl[i]) begin
            bgm = tbl[i].bn; bgm_en = tbl[i].be; mute = tbl[i].mu;
            cycle(tbl[i].tk, tbl[i].rq);
            check($sformatf("vec%0d", i), bus0.note, bus0.sfx_busy, bus0.sfx_id,
                  tbl[i].en, tbl[i].eb, tbl[i].ei);
            check_models($sformatf("vec%0d", i));
        end

        // Reset mid-hit clears outputs without a clock edge; ticks during reset ignored.
        bgm = 12'h3a5; bgm_en = 1'b1; mute = 1'b0;
        cycle(1'b1, 3'b100);
        check("rst_seq_hit0", bus0.note, bus0.sfx_busy, bus0.sfx_id, 12'h030, 1'b1, 2'd3);
        cycle(1'b1, 3'b000);
        check("rst_seq_hit1", bus0.note, bus0.sfx_busy, bus0.sfx_id, 12'h020, 1'b1, 2'd3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async/gap1", bus0.note, bus0.sfx_busy, bus0.sfx_id, 12'h000, 1'b0, 2'd0);
        check("rst_async/gap0", bus1.note, bus1.sfx_busy, bus1.sfx_id, 12'h000, 1'b0, 2'd0);
        model_reset();
        cycle(1'b1, 3'b100);
        check("rst_tick_ignored", bus0.note, bus0.sfx_busy, bus0.sfx_id, 12'h000, 1'b0, 2'd0);
        rst = 1'b0;
        cycle(1'b1, 3'b000);
        check("rst_release_bgm", bus0.note, bus0.sfx_busy, bus0.sfx_id, 12'h3a5, 1'b0, 2'd0);
        check_models("rst_release");

        for (int n = 0; n < 4000; n++) begin
            bgm    = 12'($urandom);
            bgm_en = ($urandom_range(0, 4) != 0);
            mute   = ($urandom_range(0, 9) == 0);
            cycle($urandom_range(0, 2) == 0,
                  ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
            check_models($sformatf("rand%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/audio_arbiter.md
# audio_arbiter

Schedules the single speaker tone generator between the background-music sequencer and three game sound effects (flap, score, hit). Sits between the BGM note table and the divider-preset tone generator; on every beat tick it selects which 12-bit note code ({high,med,low} nibbles) drives the tone generator. It plays short fixed SFX note sequences with strict priority and preemption, then returns to BGM after a rest gap.

## Interface
- GAP_TICKS, 1, rest ticks (note 'h000) after an SFX ends before BGM resumes; 0..7 legal
- clk  in  1  system clock; the only clock
- rst  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle beat strobe (4 Hz rate), synchronous to clk
- bgm_note  in  12  current BGM note code {high,med,low}
- bgm_en  in  1  1 = BGM audible; 0 = BGM slots output 'h000
- mute  in  1  1 = output 'h000 at every tick; sequencing continues silently
- sfx_req  in  3  one-cycle request pulses: bit0 flap, bit1 score, bit2 hit
- note  out  12  registered note code to tone generator
- sfx_busy  out  1  high while in PLAY
- sfx_id  out  2  active SFX: 0 none, 1 flap, 2 score, 3 hit

## Operation
- Priority: hit(3) > score(2) > flap(1). Multiple bits in one cycle: highest wins, others dropped.
- SFX sequences (one step per tick): flap = 'h050,'h100; score = 'h100,'h300,'h500; hit = 'h030,'h020,'h010,'h001.
- Pending register pend[1:0] (0 = none). Each cycle: if req id > pend and (state != PLAY or req id > sfx_id), pend <= req id. Requests of priority ≤ sfx_id during PLAY are discarded.
- Decision on tick uses eff = max(pend, req id this cycle, subject to the same discard rule); pend cleared when consumed.
- States: IDLE (BGM), PLAY (SFX step counter step[1:0]), GAP (rest, gap counter).
- IDLE, tick: eff != 0 -> PLAY, sfx_id <= eff, step <= 0, note <= seq[eff][0]; else note <= bgm_en ? bgm_note : 'h000.
- PLAY, tick: eff > sfx_id -> restart with eff at step 0 (preemption); else if step is last -> GAP (or IDLE with BGM note if GAP_TICKS = 0), note <= 'h000 (GAP) / BGM, sfx_id <= 0; else step+1, note <= next step.
- GAP, tick: eff != 0 -> PLAY as from IDLE; else count; after GAP_TICKS rest ticks, the next tick -> IDLE behaviour (note <= BGM).
- mute overrides only the value written to note ('h000); state, step, sfx_id advance normally.
- Reset (any time, including mid-sequence): state IDLE, note 'h000, sfx_busy 0, sfx_id 0, pend 0, step 0, gap counter 0; in-flight requests lost.

## Timing
- note, sfx_busy, sfx_id change only on the clk edge ending a tick cycle (latency 1 clk from tick); stable between ticks.
- Request pulse arriving on the tick cycle is acted on at that tick; arriving between ticks is acted on at the next tick.
- bgm_note sampled only on tick cycles.
- SFX of N steps occupies exactly N ticks of note, then GAP_TICKS ticks of 'h000.
- tick while rst high is ignored; first tick after release behaves as IDLE.

## Structure
- Shared package: note-code constants (NOTE_REST = 'h000 etc.), SFX id constants, sequence lengths and step ROM contents, state encoding.
- One natural sub-module: sfx_rom (combinational id, step -> note code, last-step flag).
- Top holds pending logic, FSM, step/gap counters, output register.

## Test plan
- Idle BGM: bgm_en=1, bgm_note='h030, tick -> note='h030, sfx_busy=0, sfx_id=0; bgm_en=0 -> note='h000 at next tick.
- Flap, GAP_TICKS=1: pulse bit0 between ticks -> next ticks note 'h050, 'h100, 'h000, then bgm_note; sfx_busy high for exactly 2 ticks.
- Preemption: flap started, at its 2nd tick pulse bit2 same cycle -> note 'h030 at that tick, sfx_id=3, then 'h020,'h010,'h001.
- Discard: during score, pulse bit0 -> ignored; score completes 'h100,'h300,'h500 and no flap follows.
- Simultaneous 3'b011 in IDLE -> score plays; mute=1 mid-score -> note 'h000 while sfx_id=2 and step still advances; sequence ends on schedule.
- Reset mid-hit (after 'h020) -> immediately note 'h000, sfx_busy 0, sfx_id 0; next tick after release outputs BGM.
